// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_if
//  Description : Fetch, MEM-stage and memory-side signals of the shared
//                data-memory port arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 16,
    parameter int MAX_BEATS = 3,
    parameter int BW        = $clog2(MAX_BEATS + 1)
);
    logic                        if_req;
    logic [ADDR_W-1:0]           if_addr;
    logic [DATA_W-1:0]           if_rdata;
    logic                        if_stall;
    logic                        mem_req;
    logic                        mem_we;
    logic [ADDR_W-1:0]           mem_addr;
    logic [BW-1:0]               mem_beats;
    logic [DATA_W*MAX_BEATS-1:0] mem_wdata;
    logic [DATA_W*MAX_BEATS-1:0] mem_rdata;
    logic                        mem_stall;
    logic                        mem_done;
    logic [ADDR_W-1:0]           m_addr;
    logic [DATA_W-1:0]           m_wdata;
    logic                        m_mr;
    logic                        m_mw;
    logic [DATA_W-1:0]           m_rdata;

    // Arbiter side
    modport master (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_beats, mem_wdata, m_rdata,
        output if_rdata, if_stall, mem_rdata, mem_stall, mem_done,
               m_addr, m_wdata, m_mr, m_mw
    );

    // Requester / memory side
    modport slave (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_beats, mem_wdata, m_rdata,
        input  if_rdata, if_stall, mem_rdata, mem_stall, mem_done,
               m_addr, m_wdata, m_mr, m_mw
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one data-memory port between fetch and multi-beat
//                MEM-stage transfers. Define ARB_PERF_CNT_EN for perf counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 16,
    parameter int MAX_BEATS = 3
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mem_port_arbiter_if.master bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]        perf_mem_busy,
    output logic [31:0]        perf_if_stall
`endif
);

    localparam int BW = $clog2(MAX_BEATS + 1);
    localparam logic [BW-1:0] c_max_beats = BW'(MAX_BEATS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BEAT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [BW-1:0]               r_beat_cnt;
    logic [BW-1:0]               w_cnt_nxt;
    logic [BW-1:0]               r_last;
    logic [BW-1:0]               w_last;
    logic                        r_we;
    logic [ADDR_W-1:0]           r_addr;
    logic [DATA_W*MAX_BEATS-1:0] r_wdata;
    logic [DATA_W*MAX_BEATS-1:0] r_rdata;
    logic [DATA_W-1:0]           w_beat_word;
    logic                        w_accept;

    assign w_accept      = rst && (r_state == S_IDLE) && bus.mem_req;
    assign bus.mem_rdata = r_rdata;

    // Stored as the index of the final beat: 0 means one beat, out-of-range clamps.
    always_comb begin
        if (bus.mem_beats == '0)
            w_last = '0;
        else if (bus.mem_beats >= c_max_beats)
            w_last = c_max_beats - 1'b1;
        else
            w_last = bus.mem_beats - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr  <= bus.mem_addr;
            r_we    <= bus.mem_we;
            r_last  <= w_last;
            r_wdata <= bus.mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_beat_cnt <= '0;
            r_rdata    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_cnt_nxt;
            if (r_state == S_BEAT && !r_we) begin
                for (int k = 0; k < MAX_BEATS; k++) begin
                    if (r_beat_cnt == BW'(k))
                        r_rdata[k*DATA_W +: DATA_W] <= bus.m_rdata;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_beat_cnt;
        w_beat_word   = '0;
        bus.m_addr    = '0;
        bus.m_wdata   = '0;
        bus.m_mr      = 1'b0;
        bus.m_mw      = 1'b0;
        bus.if_rdata  = '0;
        bus.if_stall  = 1'b0;
        bus.mem_stall = 1'b0;
        bus.mem_done  = 1'b0;

        for (int k = 0; k < MAX_BEATS; k++) begin
            if (r_beat_cnt == BW'(k))
                w_beat_word = r_wdata[k*DATA_W +: DATA_W];
        end

        // Every output stays quiet while reset is held, whatever the state.
        if (rst) begin
            case (r_state)
                S_IDLE: begin
                    w_cnt_nxt     = '0;
                    bus.mem_stall = bus.mem_req;
                    if (bus.mem_req)
                        w_state_nxt = S_BEAT;
                    if (bus.if_req) begin
                        bus.m_mr     = 1'b1;
                        bus.m_addr   = bus.if_addr;
                        bus.if_rdata = bus.m_rdata;
                    end
                end
                S_BEAT: begin
                    bus.m_addr    = r_addr + ADDR_W'(r_beat_cnt);
                    bus.mem_stall = 1'b1;
                    bus.if_stall  = bus.if_req;
                    if (r_we) begin
                        bus.m_mw    = 1'b1;
                        bus.m_wdata = w_beat_word;
                    end else begin
                        bus.m_mr    = 1'b1;
                    end
                    if (r_beat_cnt == r_last)
                        w_state_nxt = S_DONE;
                    else
                        w_cnt_nxt = r_beat_cnt + 1'b1;
                end
                S_DONE: begin
                    bus.mem_done = 1'b1;
                    w_state_nxt  = S_IDLE;
                    if (bus.if_req) begin
                        bus.m_mr     = 1'b1;
                        bus.m_addr   = bus.if_addr;
                        bus.if_rdata = bus.m_rdata;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] r_perf_busy;
    logic [31:0] r_perf_ifst;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_perf_busy <= '0;
            r_perf_ifst <= '0;
        end else begin
            if (r_state == S_BEAT && r_perf_busy != '1)
                r_perf_busy <= r_perf_busy + 32'd1;
            if (bus.if_req && bus.if_stall && r_perf_ifst != '1)
                r_perf_ifst <= r_perf_ifst + 32'd1;
        end
    end

    assign perf_mem_busy = r_perf_busy;
    assign perf_if_stall = r_perf_ifst;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Directed self-checking bench for mem_port_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    int          total;
    int          bad;
    logic [15:0] mem [0:1023];

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_mem_busy;
    logic [31:0] perf_if_stall;
`endif

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(16), .MAX_BEATS(3)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(16), .MAX_BEATS(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_mem_busy (perf_mem_busy),
        .perf_if_stall (perf_if_stall)
`endif
    );

    // Read-only memory model, answers combinationally on m_mr.
    assign bus.m_rdata = bus.m_mr ? mem[bus.m_addr[9:0]] : 16'h0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 32'h20; bus.mem_req = 1'b1;
        tick(); tick(); #1;
        total++; if (bus.m_mr !== 1'b0) begin bad++; $display("FAIL reset_m_mr got=%h exp=0", bus.m_mr); end
        total++; if (bus.m_mw !== 1'b0) begin bad++; $display("FAIL reset_m_mw got=%h exp=0", bus.m_mw); end
        total++; if (bus.if_rdata !== 16'h0) begin bad++; $display("FAIL reset_if_rdata got=%h exp=0", bus.if_rdata); end
        total++; if (bus.mem_stall !== 1'b0) begin bad++; $display("FAIL reset_mem_stall got=%h exp=0", bus.mem_stall); end
        total++; if (bus.mem_done !== 1'b0) begin bad++; $display("FAIL reset_mem_done got=%h exp=0", bus.mem_done); end
        total++; if (bus.mem_rdata !== 48'h0) begin bad++; $display("FAIL reset_mem_rdata got=%h exp=0", bus.mem_rdata); end
        bus.if_req = 1'b0; bus.mem_req = 1'b0; rst = 1'b1;
        tick();
    endtask

    task automatic test_if_only();
        bus.if_req = 1'b1; bus.if_addr = 32'h20;
        #1;
        total++; if (bus.if_rdata !== 16'h1234) begin bad++; $display("FAIL if_only_rdata got=%h exp=1234", bus.if_rdata); end
        total++; if (bus.if_stall !== 1'b0) begin bad++; $display("FAIL if_only_stall got=%h exp=0", bus.if_stall); end
        total++; if (bus.m_mr !== 1'b1 || bus.m_mw !== 1'b0) begin bad++; $display("FAIL if_only_strobes got=%b%b exp=10", bus.m_mr, bus.m_mw); end
        total++; if (bus.m_addr !== 32'h20) begin bad++; $display("FAIL if_only_addr got=%h exp=00000020", bus.m_addr); end
        bus.if_req = 1'b0;
        #1;
        total++; if (bus.m_mr !== 1'b0) begin bad++; $display("FAIL if_only_idle_mr got=%h exp=0", bus.m_mr); end
        tick();
    endtask

    task automatic test_write2();
        bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_addr = 32'h100; bus.mem_beats = 2'd2;
        bus.mem_wdata = {16'h0000, 16'hAAAA, 16'h5555};
        bus.if_req = 1'b1; bus.if_addr = 32'h20;
        #1;
        total++; if (bus.mem_stall !== 1'b1 || bus.m_mw !== 1'b0 || bus.if_stall !== 1'b0) begin bad++; $display("FAIL wr_c1 got stall=%b mw=%b if_stall=%b exp 1 0 0", bus.mem_stall, bus.m_mw, bus.if_stall); end
        tick(); #1;
        total++; if (bus.m_mw !== 1'b1 || bus.m_mr !== 1'b0 || bus.if_stall !== 1'b1) begin bad++; $display("FAIL wr_c2_strobes got mw=%b mr=%b if_stall=%b exp 1 0 1", bus.m_mw, bus.m_mr, bus.if_stall); end
        total++; if (bus.m_addr !== 32'h100 || bus.m_wdata !== 16'h5555) begin bad++; $display("FAIL wr_c2_beat got %h/%h exp 00000100/5555", bus.m_addr, bus.m_wdata); end
        total++; if (bus.mem_stall !== 1'b1) begin bad++; $display("FAIL wr_c2_stall got=%h exp=1", bus.mem_stall); end
        tick(); #1;
        total++; if (bus.m_mw !== 1'b1 || bus.m_addr !== 32'h101 || bus.m_wdata !== 16'hAAAA) begin bad++; $display("FAIL wr_c3_beat got mw=%b %h/%h exp 1 00000101/aaaa", bus.m_mw, bus.m_addr, bus.m_wdata); end
        total++; if (bus.mem_stall !== 1'b1 || bus.mem_done !== 1'b0) begin bad++; $display("FAIL wr_c3_ctl got stall=%b done=%b exp 1 0", bus.mem_stall, bus.mem_done); end
        tick(); #1;
        total++; if (bus.mem_done !== 1'b1 || bus.mem_stall !== 1'b0) begin bad++; $display("FAIL wr_c4_done got done=%b stall=%b exp 1 0", bus.mem_done, bus.mem_stall); end
        total++; if (bus.m_mw !== 1'b0 || bus.m_mr !== 1'b1 || bus.if_stall !== 1'b0) begin bad++; $display("FAIL wr_c4_if got mw=%b mr=%b if_stall=%b exp 0 1 0", bus.m_mw, bus.m_mr, bus.if_stall); end
        tick();
        bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.if_req = 1'b0;
        #1;
        total++; if (bus.mem_done !== 1'b0 || bus.m_mw !== 1'b0 || bus.mem_stall !== 1'b0) begin bad++; $display("FAIL wr_c5_idle got done=%b mw=%b stall=%b exp 0 0 0", bus.mem_done, bus.m_mw, bus.mem_stall); end
        tick();
    endtask

    task automatic test_read3();
        rst = 1'b0; tick(); rst = 1'b1;
        bus.if_req = 1'b1; bus.if_addr = 32'h20;
        bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 32'h200; bus.mem_beats = 2'd3;
        #1;
        total++; if (bus.if_stall !== 1'b0 || bus.if_rdata !== 16'h1234) begin bad++; $display("FAIL rd_c1_if got stall=%b data=%h exp 0 1234", bus.if_stall, bus.if_rdata); end
        total++; if (bus.mem_stall !== 1'b1) begin bad++; $display("FAIL rd_c1_stall got=%h exp=1", bus.mem_stall); end
        for (int k = 0; k < 3; k++) begin
            tick(); #1;
            total++; if (bus.if_stall !== 1'b1 || bus.m_mr !== 1'b1) begin bad++; $display("FAIL rd_beat%0d_strobe got if_stall=%b mr=%b exp 1 1", k, bus.if_stall, bus.m_mr); end
            total++; if (bus.m_addr !== 32'h200 + k) begin bad++; $display("FAIL rd_beat%0d_addr got=%h exp=%h", k, bus.m_addr, 32'h200 + k); end
        end
        tick(); #1;
        total++; if (bus.mem_done !== 1'b1 || bus.if_stall !== 1'b0 || bus.if_rdata !== 16'h1234) begin bad++; $display("FAIL rd_done got done=%b if_stall=%b if_rdata=%h exp 1 0 1234", bus.mem_done, bus.if_stall, bus.if_rdata); end
        total++; if (bus.mem_rdata !== {16'h0003, 16'h0002, 16'h0001}) begin bad++; $display("FAIL rd_data got=%h exp=000300020001", bus.mem_rdata); end
`ifdef ARB_PERF_CNT_EN
        total++; if (perf_mem_busy !== 32'd3) begin bad++; $display("FAIL perf_mem_busy got=%0d exp=3", perf_mem_busy); end
        total++; if (perf_if_stall !== 32'd3) begin bad++; $display("FAIL perf_if_stall got=%0d exp=3", perf_if_stall); end
`endif
        tick();
        bus.mem_req = 1'b0; bus.if_req = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 32'hFFFF_FFFF; bus.mem_beats = 2'd2;
        tick(); #1;
        total++; if (bus.m_addr !== 32'hFFFF_FFFF || bus.m_mr !== 1'b1) begin bad++; $display("FAIL wrap_beat0 got %h mr=%b exp ffffffff 1", bus.m_addr, bus.m_mr); end
        tick(); #1;
        total++; if (bus.m_addr !== 32'h0000_0000) begin bad++; $display("FAIL wrap_beat1 got=%h exp=00000000", bus.m_addr); end
        tick(); #1;
        total++; if (bus.mem_done !== 1'b1 || bus.mem_rdata[31:0] !== 32'hCAFE_BEEF) begin bad++; $display("FAIL wrap_data got done=%b data=%h exp 1 cafebeef", bus.mem_done, bus.mem_rdata[31:0]); end
        tick();
        bus.mem_req = 1'b0;
        tick();
    endtask

    task automatic test_clamp_zero();
        bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 32'h20; bus.mem_beats = 2'd0;
        tick(); #1;
        total++; if (bus.m_mr !== 1'b1 || bus.m_addr !== 32'h20 || bus.mem_done !== 1'b0) begin bad++; $display("FAIL clamp_beat got mr=%b addr=%h done=%b exp 1 00000020 0", bus.m_mr, bus.m_addr, bus.mem_done); end
        tick(); #1;
        total++; if (bus.mem_done !== 1'b1 || bus.mem_rdata[15:0] !== 16'h1234) begin bad++; $display("FAIL clamp_done got done=%b data=%h exp 1 1234", bus.mem_done, bus.mem_rdata[15:0]); end
        tick();
        bus.mem_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_addr = 32'h300; bus.mem_beats = 2'd3;
        bus.mem_wdata = {16'h3333, 16'h2222, 16'h1111};
        tick(); tick(); #1;
        total++; if (bus.m_mw !== 1'b1 || bus.m_addr !== 32'h301) begin bad++; $display("FAIL rstmid_beat1 got mw=%b addr=%h exp 1 00000301", bus.m_mw, bus.m_addr); end
        rst = 1'b0;
        tick(); #1;
        total++; if (bus.m_mw !== 1'b0 || bus.mem_stall !== 1'b0 || bus.mem_done !== 1'b0) begin bad++; $display("FAIL rstmid_held got mw=%b stall=%b done=%b exp 0 0 0", bus.m_mw, bus.mem_stall, bus.mem_done); end
        total++; if (bus.mem_rdata !== 48'h0) begin bad++; $display("FAIL rstmid_rdata got=%h exp=0", bus.mem_rdata); end
        rst = 1'b1; bus.mem_req = 1'b0;
        #1;
        total++; if (bus.m_mw !== 1'b0 || bus.mem_stall !== 1'b0 || bus.mem_done !== 1'b0) begin bad++; $display("FAIL rstmid_idle got mw=%b stall=%b done=%b exp 0 0 0", bus.m_mw, bus.mem_stall, bus.mem_done); end
        tick();
        bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 32'h20; bus.mem_beats = 2'd1;
        #1;
        total++; if (bus.mem_stall !== 1'b1 || bus.m_mr !== 1'b0) begin bad++; $display("FAIL rstmid_accept got stall=%b mr=%b exp 1 0", bus.mem_stall, bus.m_mr); end
        tick(); #1;
        total++; if (bus.m_mr !== 1'b1 || bus.m_mw !== 1'b0 || bus.m_addr !== 32'h20) begin bad++; $display("FAIL rstmid_beat got mr=%b mw=%b addr=%h exp 1 0 00000020", bus.m_mr, bus.m_mw, bus.m_addr); end
        tick(); #1;
        total++; if (bus.mem_done !== 1'b1 || bus.mem_rdata !== 48'h0000_0000_1234) begin bad++; $display("FAIL rstmid_done got done=%b data=%h exp 1 000000001234", bus.mem_done, bus.mem_rdata); end
        tick();
        bus.mem_req = 1'b0;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[10'h020] = 16'h1234;
        mem[10'h200] = 16'h0001;
        mem[10'h201] = 16'h0002;
        mem[10'h202] = 16'h0003;
        mem[10'h3FF] = 16'hBEEF;
        mem[10'h000] = 16'hCAFE;
        rst           = 1'b0;
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_beats = '0;
        bus.mem_wdata = '0;

        test_reset();
        test_if_only();
        test_write2();
        test_read3();
        test_wrap();
        test_clamp_zero();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
